// File: rtl/alu_share_pkg.sv
// Shared types for the ALU-sharing arbiter: FSM state encoding and the 4-bit ALU opcodes.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] NOP     = 4'b0000;
    localparam logic [3:0] ADD     = 4'b0001;
    localparam logic [3:0] SUB     = 4'b0010;
    localparam logic [3:0] AND     = 4'b0011;
    localparam logic [3:0] OR      = 4'b0100;
    localparam logic [3:0] XNOR    = 4'b0101;
    localparam logic [3:0] SHIFTL  = 4'b0110;
    localparam logic [3:0] SHIFTR  = 4'b0111;
    localparam logic [3:0] SHIFTLV = 4'b1000;
    localparam logic [3:0] SHIFTRV = 4'b1001;
    localparam logic [3:0] SLT     = 4'b1010;
    localparam logic [3:0] ASR     = 4'b1011;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Combinational pipeline ALU shared by the arbiter; undefined opcodes yield z=0, ovf=0.
module alu_share_arb_alu
    import alu_share_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            ctrl,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] z,
    output logic                  ovf
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [SHW-1:0]        shamt;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SHW-1:0];

    always_comb begin
        z   = '0;
        ovf = 1'b0;
        case (ctrl)
            ADD: begin
                z   = sum;
                ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            SUB: begin
                z   = diff;
                ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            AND:     z = a & b;
            OR:      z = a | b;
            XNOR:    z = ~(a ^ b);
            SHIFTL:  z = a << 1;
            SHIFTR:  z = a >> 1;
            SHIFTLV: z = a << shamt;
            SHIFTRV: z = a >> shamt;
            SLT:     z = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ASR:     z = $unsigned($signed(a) >>> shamt);
            default: begin
                z   = '0;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between two requesters; optional sticky overflow
// flags are enabled by defining ALU_SHARE_ARB_STICKY_OVF_EN.
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_z,
    output logic                  rsp_ovf,
`ifdef ALU_SHARE_ARB_STICKY_OVF_EN
    output logic [1:0]            ovf_sticky,
    input  logic [1:0]            ovf_clr,
`endif
    output logic                  busy
);

    state_t                state_reg;
    logic                  last_grant_reg;
    logic [3:0]            op_ctrl_reg;
    logic [DATA_WIDTH-1:0] op_a_reg;
    logic [DATA_WIDTH-1:0] op_b_reg;
    logic                  op_id_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_id_reg;
    logic [DATA_WIDTH-1:0] rsp_z_reg;
    logic                  rsp_ovf_reg;
    logic                  busy_reg;

    logic [1:0]            req_valid;
    logic [3:0]            req_ctrl [2];
    logic [DATA_WIDTH-1:0] req_a    [2];
    logic [DATA_WIDTH-1:0] req_b    [2];
    logic [1:0]            grant;
    logic                  grant_id;
    logic [DATA_WIDTH-1:0] alu_z;
    logic                  alu_ovf;

    assign req_valid = {req1_valid, req0_valid};
    assign req_ctrl[0] = req0_ctrl;
    assign req_ctrl[1] = req1_ctrl;
    assign req_a[0]    = req0_a;
    assign req_a[1]    = req1_a;
    assign req_b[0]    = req0_b;
    assign req_b[1]    = req1_b;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant = 2'b00;
        if (state_reg == IDLE && !reset) begin
            if (req_valid == 2'b11) begin
                grant = last_grant_reg ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign grant_id   = grant[1];
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    alu_share_arb_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .ctrl (op_ctrl_reg),
        .a    (op_a_reg),
        .b    (op_b_reg),
        .z    (alu_z),
        .ovf  (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            op_ctrl_reg    <= 4'd0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            op_id_reg      <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_z_reg      <= '0;
            rsp_ovf_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        op_ctrl_reg    <= req_ctrl[grant_id];
                        op_a_reg       <= req_a[grant_id];
                        op_b_reg       <= req_b[grant_id];
                        op_id_reg      <= grant_id;
                        last_grant_reg <= grant_id;
                        busy_reg       <= 1'b1;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_z_reg     <= alu_z;
                    rsp_ovf_reg   <= alu_ovf;
                    rsp_id_reg    <= op_id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_z     = rsp_z_reg;
    assign rsp_ovf   = rsp_ovf_reg;
    assign busy      = busy_reg;

`ifdef ALU_SHARE_ARB_STICKY_OVF_EN
    logic [1:0] ovf_sticky_reg;

    // Set has priority over clear so a completing overflow is never lost.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sticky
        always_ff @(posedge clk) begin
            if (reset) begin
                ovf_sticky_reg[gi] <= 1'b0;
            end else if (rsp_valid_reg && rsp_ready && rsp_ovf_reg && (rsp_id_reg == 1'(gi))) begin
                ovf_sticky_reg[gi] <= 1'b1;
            end else if (ovf_clr[gi]) begin
                ovf_sticky_reg[gi] <= 1'b0;
            end
        end
    end

    assign ovf_sticky = ovf_sticky_reg;
`endif

endmodule
